// File: rtl/player_pkg.sv
// Shared player-side definitions: laser FSM states, screen borders, spawn row.
package player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_FLYING   = 3'b010,
        ST_COOLDOWN = 3'b100
    } laser_state_e;

    localparam int unsigned LEFT_BORDER   = 8;
    localparam int unsigned RIGHT_BORDER  = 631;
    localparam int unsigned TOP_BORDER    = 8;
    localparam int unsigned LASER_SPAWN_Y = 440;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/player_laser_ctrl_counter.sv
// Generic up/down counter with clear and parallel load; clear beats load beats up beats down.
module player_laser_ctrl_counter #(
    parameter int unsigned          width_p     = 4,
    parameter logic [width_p-1:0]   reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] r_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= reset_val_p;
        end else if (clear_i) begin
            r_count <= reset_val_p;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (up_i) begin
            r_count <= r_count + 1'b1;
        end else if (down_i) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/player_laser_ctrl.sv
// Single player laser: spawn at the gun on a fresh shoot press, climb on frame ticks,
// retire on hit or top border, then sit out a tick-counted cooldown.
module player_laser_ctrl
    import player_pkg::*;
#(
    parameter int unsigned speed_div_p  = 4,
    parameter int unsigned step_p       = 4,
    parameter int unsigned spawn_y_p    = LASER_SPAWN_Y,
    parameter int unsigned top_border_p = TOP_BORDER,
    parameter int unsigned cooldown_p   = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_i,
    input  logic       shoot_i,
    input  logic       alive_i,
    input  logic       freeze_i,
    input  logic [9:0] gun_pos_i,
    input  logic       hit_target_i,
    output logic       laser_active_o,
    output logic [9:0] laser_x_o,
    output logic [9:0] laser_y_o,
    output logic       shot_fired_o,
    output logic       miss_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    localparam int unsigned DIV_W = cnt_width(speed_div_p - 1);
    localparam int unsigned CD_W  = cnt_width(cooldown_p);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(speed_div_p - 1);
    localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(cooldown_p);
    localparam logic [10:0]      Y_GUARD  = 11'(top_border_p + step_p);
    localparam logic [9:0]       Y_STEP   = 10'(step_p);
    localparam logic [9:0]       Y_SPAWN  = 10'(spawn_y_p);

    laser_state_e r_state, w_state_nx;
    logic         r_shoot_q;
    logic         r_active, w_active_nx;
    logic [9:0]   r_x, w_x_nx;
    logic [9:0]   r_y, w_y_nx;
    logic         r_shot, w_shot_nx;
    logic         r_miss, w_miss_nx;
    logic         r_busy;

    logic             w_rise, w_tick_run;
    logic             w_div_clr, w_div_up;
    logic             w_cd_load, w_cd_dn;
    logic [DIV_W-1:0] w_div;
    logic [CD_W-1:0]  w_cd;

    assign w_rise     = shoot_i & ~r_shoot_q;
    assign w_tick_run = tick_i & ~freeze_i;

    player_laser_ctrl_counter #(
        .width_p     (DIV_W),
        .reset_val_p ('0)
    ) u_div (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (w_div_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .up_i       (w_div_up),
        .down_i     (1'b0),
        .count_o    (w_div)
    );

    player_laser_ctrl_counter #(
        .width_p     (CD_W),
        .reset_val_p ('0)
    ) u_cooldown (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (1'b0),
        .load_i     (w_cd_load),
        .load_val_i (CD_LOAD),
        .up_i       (1'b0),
        .down_i     (w_cd_dn),
        .count_o    (w_cd)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_active_nx = r_active;
        w_x_nx      = r_x;
        w_y_nx      = r_y;
        w_shot_nx   = 1'b0;
        w_miss_nx   = 1'b0;
        w_div_clr   = 1'b0;
        w_div_up    = 1'b0;
        w_cd_load   = 1'b0;
        w_cd_dn     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise && alive_i && !freeze_i) begin
                    w_state_nx  = ST_FLYING;
                    w_active_nx = 1'b1;
                    w_x_nx      = gun_pos_i;
                    w_y_nx      = Y_SPAWN;
                    w_shot_nx   = 1'b1;
                    w_div_clr   = 1'b1;
                end
            end
            ST_FLYING: begin
                if (!alive_i) begin
                    w_state_nx  = ST_IDLE;
                    w_active_nx = 1'b0;
                    w_x_nx      = '0;
                    w_y_nx      = '0;
                    w_div_clr   = 1'b1;
                end else if (hit_target_i) begin
                    w_state_nx  = ST_COOLDOWN;
                    w_active_nx = 1'b0;
                    w_x_nx      = '0;
                    w_y_nx      = '0;
                    w_div_clr   = 1'b1;
                    w_cd_load   = 1'b1;
                end else if (w_tick_run) begin
                    if (w_div == DIV_LAST) begin
                        w_div_clr = 1'b1;
                        // Guard before subtracting so y never wraps below zero.
                        if ({1'b0, r_y} < Y_GUARD) begin
                            w_state_nx  = ST_COOLDOWN;
                            w_active_nx = 1'b0;
                            w_x_nx      = '0;
                            w_y_nx      = '0;
                            w_miss_nx   = 1'b1;
                            w_cd_load   = 1'b1;
                        end else begin
                            w_y_nx = r_y - Y_STEP;
                        end
                    end else begin
                        w_div_up = 1'b1;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (!alive_i) begin
                    w_state_nx = ST_IDLE;
                end else if (!freeze_i) begin
                    if (w_cd == '0) begin
                        w_state_nx = ST_IDLE;
                    end else if (tick_i) begin
                        w_cd_dn = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_active_nx = 1'b0;
                w_x_nx      = '0;
                w_y_nx      = '0;
                w_div_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_shoot_q <= 1'b0;
            r_active  <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_shot    <= 1'b0;
            r_miss    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_shoot_q <= shoot_i;
            r_active  <= w_active_nx;
            r_x       <= w_x_nx;
            r_y       <= w_y_nx;
            r_shot    <= w_shot_nx;
            r_miss    <= w_miss_nx;
            r_busy    <= (w_state_nx != ST_IDLE);
        end
    end

    assign laser_active_o = r_active;
    assign laser_x_o      = r_x;
    assign laser_y_o      = r_y;
    assign shot_fired_o   = r_shot;
    assign miss_o         = r_miss;
    assign busy_o         = r_busy;
    assign state_o        = r_state;

endmodule

// File: tb/tb_player_laser_ctrl.sv
// Randomized bench for player_laser_ctrl: stimulus pushes model predictions, a monitor compares.
module tb_player_laser_ctrl;

    localparam int SPEED = 4;
    localparam int STEP  = 4;
    localparam int SPAWN = 440;
    localparam int TOP   = 8;
    localparam int CD    = 16;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       tick_i = 1'b0;
    logic       shoot_i = 1'b0;
    logic       alive_i = 1'b1;
    logic       freeze_i = 1'b0;
    logic [9:0] gun_pos_i = 10'd250;
    logic       hit_target_i = 1'b0;
    logic       laser_active_o;
    logic [9:0] laser_x_o;
    logic [9:0] laser_y_o;
    logic       shot_fired_o;
    logic       miss_o;
    logic       busy_o;
    logic [2:0] state_o;

    player_laser_ctrl #(
        .speed_div_p  (SPEED),
        .step_p       (STEP),
        .spawn_y_p    (SPAWN),
        .top_border_p (TOP),
        .cooldown_p   (CD)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .tick_i         (tick_i),
        .shoot_i        (shoot_i),
        .alive_i        (alive_i),
        .freeze_i       (freeze_i),
        .gun_pos_i      (gun_pos_i),
        .hit_target_i   (hit_target_i),
        .laser_active_o (laser_active_o),
        .laser_x_o      (laser_x_o),
        .laser_y_o      (laser_y_o),
        .shot_fired_o   (shot_fired_o),
        .miss_o         (miss_o),
        .busy_o         (busy_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
        logic       shot;
        logic       miss;
        logic       busy;
        logic [2:0] state;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: mode 0 idle, 1 flying, 2 cooldown; ticks counted down to next step.
    int m_mode = 0, m_x = 0, m_y = 0, m_ticks_left = 0, m_cd_left = 0;
    bit m_prev_shoot = 0, m_shot = 0, m_miss = 0;

    function automatic obs_t model_out();
        obs_t e;
        e.active = (m_mode == 1);
        e.x      = e.active ? 10'(m_x) : 10'd0;
        e.y      = e.active ? 10'(m_y) : 10'd0;
        e.shot   = m_shot;
        e.miss   = m_miss;
        e.busy   = (m_mode != 0);
        e.state  = 3'(1 << m_mode);
        return e;
    endfunction

    function automatic obs_t dut_out();
        obs_t o;
        o.active = laser_active_o;
        o.x      = laser_x_o;
        o.y      = laser_y_o;
        o.shot   = shot_fired_o;
        o.miss   = miss_o;
        o.busy   = busy_o;
        o.state  = state_o;
        return o;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev_shoot = 0; m_shot = 0; m_miss = 0;
    endtask

    task automatic model_edge();
        bit rise;
        if (reset_i) begin
            model_reset();
            return;
        end
        rise = shoot_i && !m_prev_shoot;
        m_prev_shoot = shoot_i;
        m_shot = 0;
        m_miss = 0;
        case (m_mode)
            0: if (rise && alive_i && !freeze_i) begin
                m_mode = 1; m_x = int'(gun_pos_i); m_y = SPAWN;
                m_ticks_left = SPEED; m_shot = 1;
            end
            1: if (!alive_i) m_mode = 0;
               else if (hit_target_i) begin m_mode = 2; m_cd_left = CD; end
               else if (tick_i && !freeze_i) begin
                   m_ticks_left--;
                   if (m_ticks_left == 0) begin
                       m_ticks_left = SPEED;
                       if (m_y - STEP < TOP) begin
                           m_mode = 2; m_cd_left = CD; m_miss = 1;
                       end else m_y = m_y - STEP;
                   end
               end
            default: if (!alive_i) m_mode = 0;
               else if (!freeze_i) begin
                   if (m_cd_left == 0) m_mode = 0;
                   else if (tick_i) m_cd_left--;
               end
        endcase
    endtask

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t act: a=%0b x=%0d y=%0d shot=%0b miss=%0b busy=%0b st=%b exp: a=%0b x=%0d y=%0d shot=%0b miss=%0b busy=%0b st=%b",
                      name, $time, act.active, act.x, act.y, act.shot, act.miss, act.busy, act.state,
                      exp.active, exp.x, exp.y, exp.shot, exp.miss, exp.busy, exp.state);
    endtask

    function automatic bit chance(input int unsigned pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow t=%0t act=empty required=entry", $time);
            end else begin
                compare("cycle_outputs", dut_out(), exp_q.pop_front());
            end
        end
    end

    // Kill the laser with reset between edges; outputs must clear before the next edge.
    task automatic async_reset();
        obs_t zero;
        zero = '0;
        zero.state = 3'b001;
        #1 reset_i = 1'b1;
        #1 compare("async_reset", dut_out(), zero);
        exp_q.delete();
        model_reset();
        exp_q.push_back(model_out());
    endtask

    // Phases: tick%, shoot toggle%, hit%, freeze toggle%, alive-drop%, shoot held, cycles
    typedef struct {
        int tick; int shoot; int hit; int frz; int die; bit hold; int len;
    } phase_t;
    phase_t phases[$];

    initial begin
        phases.push_back('{100, 5, 0, 0, 0, 0, 3000});
        phases.push_back('{ 60, 10, 2, 0, 1, 0, 3000});
        phases.push_back('{ 80, 10, 1, 3, 0, 0, 3000});
        phases.push_back('{100, 0, 0, 0, 0, 1, 1500});
        phases.push_back('{ 50, 20, 3, 2, 2, 0, 3000});
        phases.push_back('{100, 8, 0, 0, 0, 0, 1500});

        foreach (phases[p]) begin
            for (int c = 0; c < phases[p].len; c++) begin
                @(posedge clk_i);
                model_edge();
                exp_q.push_back(model_out());
                if ((p == 1 || p == 4) && (c % 500 == 250) && m_mode == 1) begin
                    async_reset();
                end else begin
                    #1;
                    reset_i      = 1'b0;
                    tick_i       = chance(phases[p].tick);
                    gun_pos_i    = 10'($urandom_range(631, 8));
                    hit_target_i = chance(phases[p].hit);
                    alive_i      = !chance(phases[p].die);
                    if (chance(phases[p].frz)) freeze_i = !freeze_i;
                    if (phases[p].frz == 0) freeze_i = 1'b0;
                    if (phases[p].hold) shoot_i = 1'b1;
                    else if (chance(phases[p].shoot)) shoot_i = !shoot_i;
                end
            end
        end
        @(posedge clk_i);
        model_edge();
        exp_q.push_back(model_out());
        @(negedge clk_i);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
